fht_input_loader: RTL

FHT_INPUT_LOADER -- requirements
Module: fht_input_loader

---
 rtl/fht_input_loader.sv | 117 +++++++++++
 1 files changed

// File: rtl/fht_input_loader.sv
// Loads a natural-order sample stream into four FHT memory banks in bit-reversed
// order, then hands the frame to the FHT controller and waits for it to finish.
module fht_input_loader #(
    parameter int unsigned A_BIT = 8,
    parameter int unsigned D_BIT = 16,
    parameter int unsigned N_BIT = A_BIT + 2
) (
    input  logic             iCLK,
    input  logic             iRESET,
    input  logic [D_BIT-1:0] iDATA,
    input  logic             iVALID,
    output logic             oREADY,
    input  logic             iFHT_RDY,
    output logic [D_BIT-1:0] oWR_DATA,
    output logic [A_BIT-1:0] oWR_ADDR,
    output logic [3:0]       oWE,
    output logic             oSTART,
    output logic             oBUSY,
    output logic             oFRAME_DONE
);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_LOAD     = 3'd1;
    localparam logic [2:0] S_WAIT_RDY = 3'd2;
    localparam logic [2:0] S_START    = 3'd3;
    localparam logic [2:0] S_RUN      = 3'd4;

    localparam logic [N_BIT-1:0] CNT_LAST = {N_BIT{1'b1}};

    logic [2:0]       r_state;
    logic [2:0]       w_state_nxt;
    logic [N_BIT-1:0] r_cnt;
    logic [N_BIT-1:0] w_rev;
    logic [1:0]       w_bank;
    logic             w_accept;
    logic             r_seen_low;
    logic             r_start;
    logic             r_frame_done;
    logic [3:0]       r_we;
    logic [D_BIT-1:0] r_wr_data;
    logic [A_BIT-1:0] r_wr_addr;

    assign oREADY   = (r_state == S_LOAD);
    assign w_accept = iVALID & oREADY;

    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    always_comb begin
        w_rev = '0;
        for (int i = 0; i < int'(N_BIT); i++) begin
            w_rev[i] = r_cnt[N_BIT-1-i];
        end
    end

    // The two top bits of the reversed index pick the bank; the rest is the bank address.
    assign w_bank = w_rev[N_BIT-1 -: 2];

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:     w_state_nxt = S_LOAD;
            S_LOAD:     if (w_accept && (r_cnt == CNT_LAST)) w_state_nxt = S_WAIT_RDY;
            S_WAIT_RDY: if (iFHT_RDY) w_state_nxt = S_START;
            S_START:    w_state_nxt = S_RUN;
            S_RUN:      if (r_seen_low && iFHT_RDY) w_state_nxt = S_LOAD;
            default:    w_state_nxt = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_seen_low   <= 1'b0;
            r_start      <= 1'b0;
            r_frame_done <= 1'b0;
        end else begin
            r_state      <= w_state_nxt;
            r_start      <= (w_state_nxt == S_START);
            r_frame_done <= (r_state == S_RUN) && (w_state_nxt == S_LOAD);
            if (w_accept) begin
                r_cnt <= r_cnt + 1'b1;
            end
            // The controller may still show a stale idle flag on the START cycle, so a
            // finish only counts after it has been seen busy at least once in RUN.
            if (r_state == S_START) begin
                r_seen_low <= 1'b0;
            end else if ((r_state == S_RUN) && !iFHT_RDY) begin
                r_seen_low <= 1'b1;
            end
        end
    end

    always_ff @(posedge iCLK or negedge iRESET) begin
        if (!iRESET) begin
            r_we      <= 4'b0000;
            r_wr_data <= '0;
            r_wr_addr <= '0;
        end else begin
            r_we <= 4'b0000;
            if (w_accept) begin
                r_we      <= 4'b0001 << w_bank;
                r_wr_data <= iDATA;
                r_wr_addr <= w_rev[A_BIT-1:0];
            end
        end
    end

    assign oWE         = r_we;
    assign oWR_DATA    = r_wr_data;
    assign oWR_ADDR    = r_wr_addr;
    assign oSTART      = r_start;
    assign oFRAME_DONE = r_frame_done;
    assign oBUSY       = (r_state == S_WAIT_RDY) || (r_state == S_START) || (r_state == S_RUN) ||
                         ((r_state == S_LOAD) && (r_cnt != '0));

endmodule
